alarm_key_controller: RTL and testbench

//  Keypad-entry sequencer for the alarm clock. Collects four BCD digits into a shift buffer and validates them.

---
 rtl/alarm_pkg.sv | 27 ++
 rtl/alarm_key_controller_key_buffer.sv | 41 ++++
 rtl/alarm_key_controller.sv | 149 ++++++++++++++
 tb/tb_alarm_key_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock: FSM state encoding, keypad codes and BCD digit type.
// Used by the key controller, the time counter and the display mux.
package alarm_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4
    } state_t;

    localparam logic [3:0] DEFAULT_KEY_ALARM = 4'hA;
    localparam logic [3:0] DEFAULT_KEY_TIME  = 4'hB;
    localparam logic [3:0] DEFAULT_KEY_NONE  = 4'hF;
    localparam int unsigned DEFAULT_TIMEOUT_SEC = 10;

    // A 24-hour HH:MM value in BCD; 20..23 is the only legal range once the tens-of-hours digit is 2.
    function automatic logic bcd_time_valid(input bcd_t ms_hr, input bcd_t ls_hr,
                                            input bcd_t ms_min, input bcd_t ls_min);
        return (ms_hr <= 4'd2) && (ls_hr <= 4'd9) && (ms_min <= 4'd5) && (ls_min <= 4'd9) &&
               !((ms_hr == 4'd2) && (ls_hr > 4'd3));
    endfunction

endpackage

// File: rtl/alarm_key_controller_key_buffer.sv
// Four-digit BCD entry shift register; a clear in the same cycle as a shift
// starts a fresh entry with the new digit in the least significant position.
module key_buffer
    import alarm_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic shift,
    input  bcd_t digit,
    output bcd_t ms_hr,
    output bcd_t ls_hr,
    output bcd_t ms_min,
    output bcd_t ls_min,
    output logic valid
);

    bcd_t ms_hr_r, ls_hr_r, ms_min_r, ls_min_r;

    // Digit storage: clear and shift controls from the controller FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r} <= 16'h0000;
        end else if (clear && shift) begin
            {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r} <= {12'h000, digit};
        end else if (clear) begin
            {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r} <= 16'h0000;
        end else if (shift) begin
            {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r} <= {ls_hr_r, ms_min_r, ls_min_r, digit};
        end else begin
            {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r} <= {ms_hr_r, ls_hr_r, ms_min_r, ls_min_r};
        end
    end

    assign ms_hr  = ms_hr_r;
    assign ls_hr  = ls_hr_r;
    assign ms_min = ms_min_r;
    assign ls_min = ls_min_r;
    assign valid  = bcd_time_valid(ms_hr_r, ls_hr_r, ms_min_r, ls_min_r);

endmodule

// File: rtl/alarm_key_controller.sv
// Keypad entry sequencer: collects four BCD digits, validates them and pulses
// a load into the time counter or alarm register; aborts idle entries on timeout.
module alarm_key_controller
    import alarm_pkg::*;
#(
    parameter int unsigned TIMEOUT_SEC = DEFAULT_TIMEOUT_SEC,
    parameter logic [3:0]  KEY_ALARM   = DEFAULT_KEY_ALARM,
    parameter logic [3:0]  KEY_TIME    = DEFAULT_KEY_TIME,
    parameter logic [3:0]  KEY_NONE    = DEFAULT_KEY_NONE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    output logic [3:0] key_buf_ms_hr,
    output logic [3:0] key_buf_ls_hr,
    output logic [3:0] key_buf_ms_min,
    output logic [3:0] key_buf_ls_min,
    output logic       load_new_c,
    output logic       load_new_a,
    output logic       show_new_time,
    output logic       show_a,
    output logic       entry_error
);

    localparam logic [3:0] TIMEOUT_VAL = TIMEOUT_SEC[3:0];

    state_t     state_r, state_nxt_s;
    logic [3:0] timer_r;
    logic       load_c_r, load_a_r, error_r;
    logic       load_c_nxt_s, load_a_nxt_s, error_nxt_s;
    logic       clear_s, shift_s, buf_valid_s;
    logic       is_digit_s, timeout_s;

    assign is_digit_s = (key <= 4'd9);
    assign timeout_s  = (timer_r == TIMEOUT_VAL);

    key_buffer u_key_buffer (
        .clk    (clk),
        .reset  (reset),
        .clear  (clear_s),
        .shift  (shift_s),
        .digit  (key),
        .ms_hr  (key_buf_ms_hr),
        .ls_hr  (key_buf_ls_hr),
        .ms_min (key_buf_ms_min),
        .ls_min (key_buf_ls_min),
        .valid  (buf_valid_s)
    );

    // State, inactivity timer and load/error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= SHOW_TIME;
            timer_r  <= 4'd0;
            load_c_r <= 1'b0;
            load_a_r <= 1'b0;
            error_r  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            load_c_r <= load_c_nxt_s;
            load_a_r <= load_a_nxt_s;
            error_r  <= error_nxt_s;
            if ((state_r == KEY_WAITED) || (state_r == KEY_ENTRY)) begin
                if (one_second && !timeout_s) begin
                    timer_r <= timer_r + 4'd1;
                end else begin
                    timer_r <= timer_r;
                end
            end else begin
                timer_r <= 4'd0;
            end
        end
    end

    // Next state and buffer control; the buffer is held clear while showing time,
    // so a just-loaded value stays visible for the one pulse cycle.
    always_comb begin
        state_nxt_s  = state_r;
        clear_s      = 1'b0;
        shift_s      = 1'b0;
        load_c_nxt_s = 1'b0;
        load_a_nxt_s = 1'b0;
        error_nxt_s  = 1'b0;
        case (state_r)
            SHOW_TIME: begin
                clear_s = 1'b1;
                if (is_digit_s) begin
                    shift_s     = 1'b1;
                    state_nxt_s = KEY_STORED;
                end else if (key == KEY_ALARM) begin
                    state_nxt_s = SHOW_ALARM;
                end else begin
                    state_nxt_s = SHOW_TIME;
                end
            end
            KEY_STORED: begin
                state_nxt_s = KEY_WAITED;
            end
            KEY_WAITED: begin
                if (key == KEY_NONE) begin
                    state_nxt_s = KEY_ENTRY;
                end else if (timeout_s) begin
                    clear_s     = 1'b1;
                    state_nxt_s = SHOW_TIME;
                end else begin
                    state_nxt_s = KEY_WAITED;
                end
            end
            KEY_ENTRY: begin
                if (is_digit_s) begin
                    shift_s     = 1'b1;
                    state_nxt_s = KEY_STORED;
                end else if (key == KEY_TIME) begin
                    load_c_nxt_s = buf_valid_s;
                    error_nxt_s  = !buf_valid_s;
                    state_nxt_s  = SHOW_TIME;
                end else if (key == KEY_ALARM) begin
                    load_a_nxt_s = buf_valid_s;
                    error_nxt_s  = !buf_valid_s;
                    state_nxt_s  = SHOW_TIME;
                end else if (timeout_s) begin
                    clear_s     = 1'b1;
                    state_nxt_s = SHOW_TIME;
                end else begin
                    state_nxt_s = KEY_ENTRY;
                end
            end
            SHOW_ALARM: begin
                if (key == KEY_ALARM) begin
                    state_nxt_s = SHOW_ALARM;
                end else begin
                    state_nxt_s = SHOW_TIME;
                end
            end
            default: begin
                clear_s     = 1'b1;
                state_nxt_s = SHOW_TIME;
            end
        endcase
    end

    assign load_new_c    = load_c_r;
    assign load_new_a    = load_a_r;
    assign entry_error   = error_r;
    assign show_new_time = (state_r == KEY_STORED) || (state_r == KEY_WAITED) || (state_r == KEY_ENTRY);
    assign show_a        = (state_r == SHOW_ALARM);

endmodule

// File: tb/tb_alarm_key_controller.sv
// Directed bench for alarm_key_controller: expected load/error pulses go into a
// scoreboard queue and a negedge monitor pops and compares each pulse it sees.
module tb_alarm_key_controller;
    import alarm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       one_second;
    logic [3:0] key;
    logic [3:0] key_buf_ms_hr, key_buf_ls_hr, key_buf_ms_min, key_buf_ls_min;
    logic       load_new_c, load_new_a, show_new_time, show_a, entry_error;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [2:0]  pulses;   // {load_new_c, load_new_a, entry_error}
        logic [15:0] buf_val;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic [15:0] buf_w;
    assign buf_w = {key_buf_ms_hr, key_buf_ls_hr, key_buf_ms_min, key_buf_ls_min};

    alarm_key_controller dut (
        .clk            (clk),
        .reset          (reset),
        .one_second     (one_second),
        .key            (key),
        .key_buf_ms_hr  (key_buf_ms_hr),
        .key_buf_ls_hr  (key_buf_ls_hr),
        .key_buf_ms_min (key_buf_ms_min),
        .key_buf_ls_min (key_buf_ls_min),
        .load_new_c     (load_new_c),
        .load_new_a     (load_new_a),
        .show_new_time  (show_new_time),
        .show_a         (show_a),
        .entry_error    (entry_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pulse monitor: every pulse cycle must match the head of the scoreboard
    always @(negedge clk) begin
        if (load_new_c || load_new_a || entry_error) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse: got cae=%b buf=%h expected no pulse",
                         {load_new_c, load_new_a, entry_error}, buf_w);
            end else begin
                mon_e = sb.pop_front();
                if ({load_new_c, load_new_a, entry_error, buf_w} !== mon_e) begin
                    bad++;
                    $display("FAIL pulse_check: got cae=%b buf=%h expected cae=%b buf=%h",
                             {load_new_c, load_new_a, entry_error}, buf_w, mon_e.pulses, mon_e.buf_val);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic digit(input logic [3:0] d);
        key = d;
        tick(3);
        key = 4'hF;
        tick(2);
    endtask

    task automatic func_key(input logic [3:0] k, input logic [2:0] p, input logic [15:0] b,
                            input string name);
        sb.push_back({p, b});
        key = k;
        tick(1);
        key = 4'hF;
        tick(3);
        chk({name, "_drained"}, sb.size(), 32'd0);
        chk({name, "_buf_cleared"}, {16'h0000, buf_w}, 32'h0000_0000);
        chk({name, "_show_new_time"}, {31'd0, show_new_time}, 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        key        = 4'hF;
        one_second = 1'b0;
        tick(2);
        chk("reset_state", {11'd0, buf_w, load_new_c, load_new_a, entry_error, show_new_time, show_a},
            32'd0);
        reset = 1'b0;
        tick(1);

        // valid time entry
        digit(4'd1); digit(4'd2); digit(4'd3); digit(4'd4);
        chk("entry_1234_buf", {16'h0000, buf_w}, 32'h0000_1234);
        chk("entry_show_new_time", {31'd0, show_new_time}, 32'd1);
        func_key(4'hB, 3'b100, 16'h1234, "load_time");

        // valid alarm entry
        digit(4'd0); digit(4'd6); digit(4'd3); digit(4'd0);
        func_key(4'hA, 3'b010, 16'h0630, "load_alarm");

        // 24:00 is invalid
        digit(4'd2); digit(4'd4); digit(4'd0); digit(4'd0);
        func_key(4'hB, 3'b001, 16'h2400, "bad_entry");

        // held key shifts exactly once
        key = 4'd5;
        tick(20);
        chk("held_key_buf", {16'h0000, buf_w}, 32'h0000_0005);
        chk("held_key_show_new_time", {31'd0, show_new_time}, 32'd1);
        key = 4'hF;
        tick(2);
        digit(4'd6);
        chk("two_digit_buf", {16'h0000, buf_w}, 32'h0000_0056);
        func_key(4'hB, 3'b100, 16'h0056, "two_digit");

        // inactivity abort after 10 strobes, not 9
        digit(4'd1);
        chk("abort_entry_buf", {16'h0000, buf_w}, 32'h0000_0001);
        repeat (9) begin
            one_second = 1'b1;
            tick(1);
            one_second = 1'b0;
            tick(1);
        end
        chk("before_timeout_show_new_time", {31'd0, show_new_time}, 32'd1);
        one_second = 1'b1;
        tick(1);
        one_second = 1'b0;
        tick(2);
        chk("abort_show_new_time", {31'd0, show_new_time}, 32'd0);
        chk("abort_buf", {16'h0000, buf_w}, 32'h0000_0000);

        // alarm display while held
        key = 4'hA;
        tick(1);
        chk("show_a_press", {31'd0, show_a}, 32'd1);
        tick(4);
        chk("show_a_held", {30'd0, show_a, show_new_time}, 32'd2);
        key = 4'hF;
        tick(1);
        chk("show_a_release", {31'd0, show_a}, 32'd0);

        // reset mid-entry
        digit(4'd7); digit(4'd8);
        chk("pre_reset_buf", {16'h0000, buf_w}, 32'h0000_0078);
        reset = 1'b1;
        tick(1);
        chk("reset_mid_entry", {11'd0, buf_w, load_new_c, load_new_a, entry_error, show_new_time, show_a},
            32'd0);
        reset = 1'b0;
        tick(2);
        chk("final_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
